// File: rtl/charlieplex_digits.sv
// Multi-digit hex scanner for charlieplexed 7-segment boards on eight shared lines.
// Inputs are latched once per frame; each digit slot is blanked, then lit for BRIGHT+1 ticks.
module charlieplex_digits #(
    parameter int N_DIGITS    = 8,
    parameter int CLK_DIV     = 100,
    parameter int BLANK_TICKS = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] VALUE,
    input  logic [7:0]  DIG_EN,
    input  logic [3:0]  BRIGHT,
    output logic [7:0]  S_O,
    output logic [7:0]  S_OE,
    output logic        FRAME_STB
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]      PH_MAX   = 5'(BLANK_TICKS + 15);
    localparam logic [4:0]      PH_BLANK = 5'(BLANK_TICKS);
    localparam logic [2:0]      DIG_LAST = 3'(N_DIGITS - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       phase;
    logic [2:0]       digit;
    logic [31:0]      sh_value;
    logic [7:0]       sh_en;
    logic [3:0]       sh_bright;

    logic       tick;
    logic       slot_end;
    logic       frame_end;
    logic       lit;
    logic [6:0] seg;
    logic [7:0] seg_lo;
    logic [7:0] seg_up;
    logic [7:0] line_o;
    logic [7:0] line_oe;

    function automatic logic [6:0] hex_font(input logic [3:0] n);
        logic [6:0] f;
        case (n)
            4'h0: f = 7'h3F;
            4'h1: f = 7'h06;
            4'h2: f = 7'h5B;
            4'h3: f = 7'h4F;
            4'h4: f = 7'h66;
            4'h5: f = 7'h6D;
            4'h6: f = 7'h7D;
            4'h7: f = 7'h07;
            4'h8: f = 7'h7F;
            4'h9: f = 7'h6F;
            4'hA: f = 7'h77;
            4'hB: f = 7'h7C;
            4'hC: f = 7'h39;
            4'hD: f = 7'h5E;
            4'hE: f = 7'h79;
            default: f = 7'h71;
        endcase
        return f;
    endfunction

    assign tick      = (div_cnt == DIV_LAST);
    assign slot_end  = tick && (phase == PH_MAX);
    assign frame_end = slot_end && (digit == DIG_LAST);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt   <= '0;
            phase     <= PH_MAX;
            digit     <= DIG_LAST;
            sh_value  <= '0;
            sh_en     <= '0;
            sh_bright <= '0;
            FRAME_STB <= 1'b0;
            S_O       <= '0;
            S_OE      <= '0;
        end else begin
            div_cnt   <= tick ? '0 : div_cnt + 1'b1;
            FRAME_STB <= frame_end;
            S_O       <= line_o;
            S_OE      <= line_oe;
            if (tick) begin
                if (phase == PH_MAX) begin
                    phase <= '0;
                    digit <= (digit == DIG_LAST) ? 3'd0 : digit + 3'd1;
                end else begin
                    phase <= phase + 5'd1;
                end
            end
            // Reset state sits at the last phase of the last digit, so the first tick latches too.
            if (frame_end) begin
                sh_value  <= VALUE;
                sh_en     <= DIG_EN;
                sh_bright <= BRIGHT;
            end
        end
    end

    always_comb begin
        seg     = hex_font(sh_value[{digit, 2'b00} +: 4]);
        seg_lo  = {1'b0, seg};
        seg_up  = {seg, 1'b0};
        lit     = sh_en[digit] && (phase >= PH_BLANK) && ((phase - PH_BLANK) <= {1'b0, sh_bright});
        line_o  = '0;
        line_oe = '0;
        if (lit) begin
            // Lines below the anode carry seg[k]; lines above it are shifted down by one.
            for (int k = 0; k < 8; k++) begin
                if (3'(k) == digit) begin
                    line_o[k]  = 1'b1;
                    line_oe[k] = 1'b1;
                end else if (3'(k) < digit) begin
                    line_oe[k] = seg_lo[k];
                end else begin
                    line_oe[k] = seg_up[k];
                end
            end
        end
    end

    no_contention: assert property (@(posedge CLK) disable iff (!RESET_N) $onehot0(S_O & S_OE));

endmodule

// File: tb/tb_charlieplex_digits.sv
// Directed bench for charlieplex_digits: an 8-digit and a 4-digit instance, CLK_DIV=2, BLANK_TICKS=2.
// Each frame is scanned slot by slot and summarised (blank lead, lit width, line pattern).
module tb_charlieplex_digits;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst2_n;
    logic [31:0] value;
    logic [7:0]  dig_en;
    logic [3:0]  bright;
    logic [7:0]  s_o1, s_oe1, s_o2, s_oe2;
    logic        stb1, stb2;
    logic        sel;
    logic [7:0]  obs_o, obs_oe;
    logic        obs_stb;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] slot_oe [8];
    logic [7:0] slot_o  [8];

    logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    assign obs_o   = sel ? s_o2  : s_o1;
    assign obs_oe  = sel ? s_oe2 : s_oe1;
    assign obs_stb = sel ? stb2  : stb1;

    charlieplex_digits #(.N_DIGITS(8), .CLK_DIV(2), .BLANK_TICKS(2)) dut8 (
        .CLK(clk), .RESET_N(rst_n), .VALUE(value), .DIG_EN(dig_en), .BRIGHT(bright),
        .S_O(s_o1), .S_OE(s_oe1), .FRAME_STB(stb1)
    );

    charlieplex_digits #(.N_DIGITS(4), .CLK_DIV(2), .BLANK_TICKS(2)) dut4 (
        .CLK(clk), .RESET_N(rst2_n), .VALUE(value), .DIG_EN(dig_en), .BRIGHT(bright),
        .S_O(s_o2), .S_OE(s_oe2), .FRAME_STB(stb2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Lit line pattern for digit d showing nibble nib: {oe, o}.
    function automatic logic [15:0] exp_lines(input int d, input logic [3:0] nib);
        logic [6:0] seg;
        logic [7:0] oe;
        logic [7:0] o;
        seg = font_tab[nib];
        oe  = '0;
        o   = '0;
        for (int k = 0; k < 8; k++) begin
            if (k == d) begin
                oe[k] = 1'b1;
                o[k]  = 1'b1;
            end else if (k < d) begin
                oe[k] = seg[k];
            end else begin
                oe[k] = seg[k-1];
            end
        end
        return {oe, o};
    endfunction

    task automatic wait_stb(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            found = obs_stb;
        end
        check_eq(tag, found, 1'b1);
    endtask

    // Called on the negedge where FRAME_STB is high; returns on the next frame's strobe cycle.
    task automatic scan_frame(input int nd, input logic [31:0] val, input logic [7:0] en,
                              input logic [3:0] br, input int chg_at, input logic [31:0] nval,
                              input logic [7:0] nen, input logic [3:0] nbr, input string tag);
        int         stray_stb;
        int         lead, lit, last_lit, e_lit, e_lead;
        logic       bad;
        logic [7:0] f_oe, f_o, e_oe, e_o;
        stray_stb = 0;
        for (int s = 0; s < nd; s++) begin
            lead = 36; lit = 0; last_lit = -1; bad = 1'b0; f_oe = '0; f_o = '0;
            for (int i = 0; i < 36; i++) begin
                @(negedge clk);
                if (s * 36 + i + 1 == nd * 36)
                    check_eq($sformatf("%s_stb_period", tag), obs_stb, 1'b1);
                else if (obs_stb)
                    stray_stb++;
                if (obs_oe != 8'h00) begin
                    if (lit == 0) begin
                        lead = i; f_oe = obs_oe; f_o = obs_o;
                    end else if (obs_oe !== f_oe || obs_o !== f_o || last_lit != i - 1) begin
                        bad = 1'b1;
                    end
                    lit++;
                    last_lit = i;
                end
                if (s * 36 + i + 1 == chg_at) begin
                    value = nval; dig_en = nen; bright = nbr;
                end
            end
            e_lit  = en[s] ? 2 * (int'(br) + 1) : 0;
            e_lead = (e_lit > 0) ? 4 : 36;
            if (e_lit > 0) {e_oe, e_o} = exp_lines(s, val[4*s +: 4]);
            else           {e_oe, e_o} = 16'h0000;
            check_eq($sformatf("%s_s%0d_lead", tag, s), lead, e_lead);
            check_eq($sformatf("%s_s%0d_width", tag, s), lit, e_lit);
            check_eq($sformatf("%s_s%0d_oe", tag, s), f_oe, e_oe);
            check_eq($sformatf("%s_s%0d_o", tag, s), f_o, e_o);
            check_eq($sformatf("%s_s%0d_steady", tag, s), bad, 1'b0);
            slot_oe[s] = f_oe;
            slot_o[s]  = f_o;
        end
        check_eq($sformatf("%s_stray_stb", tag), stray_stb, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        rst_n = 1'b0; rst2_n = 1'b0; sel = 1'b0;
        value = 32'h7654_3210; dig_en = 8'hFF; bright = 4'hF;
        repeat (3) @(negedge clk);
        check_eq("rst_oe", s_oe1, 8'h00);
        check_eq("rst_o", s_o1, 8'h00);
        check_eq("rst_stb", stb1, 1'b0);
        check_eq("rst_oe_n4", s_oe2, 8'h00);

        rst_n = 1'b1; rst2_n = 1'b1;
        @(negedge clk);
        check_eq("stb_after_1", stb1, 1'b0);
        @(negedge clk);
        check_eq("stb_after_2", stb1, 1'b1);
        check_eq("oe_at_first_stb", s_oe1, 8'h00);

        // Basic display; BRIGHT drops to 0 mid-frame and must wait for the next frame.
        scan_frame(8, 32'h7654_3210, 8'hFF, 4'hF, 100, 32'h7654_3210, 8'hFF, 4'h0, "f1");
        check_eq("f1_dig0_oe", slot_oe[0], 8'h7F);
        check_eq("f1_dig0_o", slot_o[0], 8'h01);
        check_eq("f1_dig1_oe", slot_oe[1], 8'h0E);
        check_eq("f1_dig1_o", slot_o[1], 8'h02);
        scan_frame(8, 32'h7654_3210, 8'hFF, 4'h0, 10, 32'h0000_0000, 8'hFF, 4'h7, "f2");
        scan_frame(8, 32'h0000_0000, 8'hFF, 4'h7, 120, 32'h8888_8888, 8'hFF, 4'h7, "f3");
        check_eq("f3_dig5_still_zero", slot_oe[5], 8'h7F);
        scan_frame(8, 32'h8888_8888, 8'hFF, 4'h7, 5, 32'h8888_8888, 8'hFE, 4'h7, "f4");
        check_eq("f4_dig3_oe", slot_oe[3], 8'hFF);
        check_eq("f4_dig3_o", slot_o[3], 8'h08);
        scan_frame(8, 32'h8888_8888, 8'hFE, 4'h7, -1, 32'h0, 8'h0, 4'h0, "f5");
        check_eq("f5_dig0_masked", slot_oe[0], 8'h00);

        // Asynchronous reset in the middle of a lit tick.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = (s_oe1 != 8'h00);
        end
        check_eq("lit_before_async", found, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_oe", s_oe1, 8'h00);
        check_eq("async_o", s_o1, 8'h00);
        value = 32'h7654_3210; dig_en = 8'hFF; bright = 4'h3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_stb_after_1", stb1, 1'b0);
        @(negedge clk);
        check_eq("rel_stb_after_2", stb1, 1'b1);
        scan_frame(8, 32'h7654_3210, 8'hFF, 4'h3, -1, 32'h0, 8'h0, 4'h0, "f6");
        check_eq("f6_dig0_first", slot_oe[0], 8'h7F);

        // Four-digit instance: upper nibbles and enable bits ignored, 144-cycle frames.
        sel = 1'b1;
        @(negedge clk);
        value = 32'hFFFF_C0A5; dig_en = 8'h0D; bright = 4'h1;
        wait_stb("n4_stb_seen_a");
        wait_stb("n4_stb_seen_b");
        scan_frame(4, 32'hFFFF_C0A5, 8'h0D, 4'h1, -1, 32'h0, 8'h0, 4'h0, "n4a");
        check_eq("n4_dig0_oe", slot_oe[0], 8'hDB);
        check_eq("n4_dig0_o", slot_o[0], 8'h01);
        check_eq("n4_dig2_oe", slot_oe[2], 8'h7F);
        scan_frame(4, 32'hFFFF_C0A5, 8'h0D, 4'h1, -1, 32'h0, 8'h0, 4'h0, "n4b");
        check_eq("n4_wrap_dig0", slot_oe[0], 8'hDB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
